// File: rtl/umix_pkg.sv
// umix_pkg: shared widths, sequencer state encoding and operand-mask helpers
package umix_pkg;
  localparam int WORD_W = 32;
  localparam int SEL_W = 3;
  localparam int MASK_A = 2;
  localparam int MASK_B = 1;
  localparam int MASK_C = 0;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, PRESENT, WRITE} seq_state_e;
  function automatic seq_state_e first_rd(input logic [2:0] m);
    return m[MASK_A] ? RD_A : m[MASK_B] ? RD_B : m[MASK_C] ? RD_C : PRESENT;
  endfunction
endpackage

// File: rtl/reg_bank_sequencer_if.sv
// reg_bank_sequencer_if: decode/execute/writeback handshakes plus the single bank port
interface reg_bank_sequencer_if;
  import umix_pkg::*;
  logic rd_valid;
  logic rd_ready;
  logic [2:0] rd_mask;
  logic [SEL_W-1:0] ra;
  logic [SEL_W-1:0] rb;
  logic [SEL_W-1:0] rc;
  logic op_valid;
  logic op_ready;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] op_c;
  logic wb_valid;
  logic wb_ready;
  logic [SEL_W-1:0] wb_reg;
  logic [WORD_W-1:0] wb_data;
  logic [SEL_W-1:0] bank_r;
  logic bank_s;
  logic [WORD_W-1:0] bank_d;
  logic [WORD_W-1:0] bank_q;
  modport master (
    input rd_valid, rd_mask, ra, rb, rc, op_ready, wb_valid, wb_reg, wb_data, bank_q,
    output rd_ready, op_valid, op_a, op_b, op_c, wb_ready, bank_r, bank_s, bank_d
  );
  modport slave (
    output rd_valid, rd_mask, ra, rb, rc, op_ready, wb_valid, wb_reg, wb_data, bank_q,
    input rd_ready, op_valid, op_a, op_b, op_c, wb_ready, bank_r, bank_s, bank_d
  );
endinterface

// File: rtl/reg_bank_sequencer.sv
// reg_bank_sequencer: serialises operand reads and writebacks onto one register-bank port
module reg_bank_sequencer
  import umix_pkg::*;
(
  input logic clk,
  input logic reset,
  reg_bank_sequencer_if.master bus
);
  seq_state_e state_q, state_d;
  logic [2:0] mask_q;
  logic [SEL_W-1:0] ra_q, rb_q, rc_q, wbr_q;
  logic [WORD_W-1:0] wbd_q, op_a_q, op_b_q, op_c_q;
  logic idle, rd_acc, wb_acc;
  assign idle = reset && state_q == IDLE;
  assign bus.wb_ready = idle;
  assign bus.rd_ready = idle && !bus.wb_valid;
  assign wb_acc = bus.wb_valid && idle;
  assign rd_acc = bus.rd_valid && bus.rd_ready;
  assign bus.op_valid = state_q == PRESENT;
  assign bus.op_a = op_a_q;
  assign bus.op_b = op_b_q;
  assign bus.op_c = op_c_q;
  assign bus.bank_s = state_q == WRITE;
  assign bus.bank_d = bus.bank_s ? wbd_q : '0;
  assign bus.bank_r = state_q == RD_A ? ra_q : state_q == RD_B ? rb_q :
                      state_q == RD_C ? rc_q : state_q == WRITE ? wbr_q : '0;
  // next state: writeback wins in IDLE, reads walk the mask in A,B,C order
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wb_acc ? WRITE : rd_acc ? first_rd(bus.rd_mask) : IDLE;
      RD_A:    state_d = first_rd(mask_q & 3'b011);
      RD_B:    state_d = first_rd(mask_q & 3'b001);
      RD_C:    state_d = PRESENT;
      PRESENT: state_d = bus.op_ready ? IDLE : PRESENT;
      default: state_d = IDLE;
    endcase
  end
  // state, request latches and operand capture; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
      wbr_q <= '0;
      wbd_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_c_q <= '0;
    end else begin
      state_q <= state_d;
      if (wb_acc) begin
        wbr_q <= bus.wb_reg;
        wbd_q <= bus.wb_data;
      end
      if (rd_acc) begin
        mask_q <= bus.rd_mask;
        ra_q <= bus.ra;
        rb_q <= bus.rb;
        rc_q <= bus.rc;
        op_a_q <= '0;
        op_b_q <= '0;
        op_c_q <= '0;
      end
      if (state_q == RD_A) op_a_q <= bus.bank_q;
      if (state_q == RD_B) op_b_q <= bus.bank_q;
      if (state_q == RD_C) op_c_q <= bus.bank_q;
    end
  end
endmodule
